valu_serial: RTL and testbench
==============================

VALU_SERIAL -- requirements
Module: valu_serial

Interface
REQ-001 The block SHALL have parameter ELEMS, default 16, giving the elements per vector, which SHALL equal the register-file vector length.
REQ-002 Clk1  in  1  the single clock; every flop SHALL update on posedge Clk1.
REQ-003 Rst  in  1  reset, synchronous and active-high.
REQ-004 Start  in  1  command strobe, sampled only in IDLE.
REQ-005 Op  in  2  operation select: 00 ADD (mod 2^16), 01 SUB A-B (mod 2^16), 10 SADD (signed saturating add), 11 SMAX (signed max).
REQ-006 SrcA, SrcB, Dst  in  3 each  source A, source B and destination vector-register numbers.
REQ-007 DataOut_s, DataOut2_s  in  16 each  serial element streams for A and B from the register file, valid one cycle after RD_s.
REQ-008 Addr, Addr2  out  3 each  register-file addresses.
REQ-009 RD_s, WR_s  out  1 each  register-file serial read and write enables.
REQ-010 DataIn_s  out  16  serial write-back element.
REQ-011 Busy  out  1  high in every state except IDLE.
REQ-012 Done  out  1  one-cycle completion pulse.
REQ-013 Ovf  out  1  overflow/saturation flag for the last op, valid from Done until the next accepted Start.

Function
REQ-014 The FSM SHALL have states IDLE, READ, DRAIN, WRITE and DONE, with a 4-bit element counter k.
REQ-015 In IDLE with Start=1 the block SHALL latch Op, SrcA, SrcB and Dst, clear Ovf, set k=0 and enter READ; Start outside IDLE SHALL be ignored.
REQ-016 In READ the block SHALL drive RD_s=1, Addr=SrcA and Addr2=SrcB for exactly ELEMS cycles, then enter DRAIN.
REQ-017 Element j of both streams SHALL be captured on the edge ending READ cycle j+1 (j=0..14), and element 15 on the edge ending DRAIN.
REQ-018 Each captured element SHALL be stored in result buffer entry j as f(Op, A, B).
REQ-019 ADD and SUB SHALL keep the low 16 bits of the result; Ovf SHALL set if any element's unsigned carry-out (ADD) or borrow (SUB) occurs.
REQ-020 SADD SHALL clamp to 0x7FFF or 0x8000 on signed overflow and SHALL set Ovf if any element clamps.
REQ-021 SMAX SHALL return the signed-greater operand, SHALL return A on a tie, and SHALL never set Ovf.
REQ-022 DRAIN SHALL last one cycle with RD_s=0 and WR_s=0, guaranteeing the register file a deasserted-enable gap, then enter WRITE with k=0.
REQ-023 In WRITE the block SHALL drive WR_s=1, Addr=Dst and DataIn_s=buffer[k] for ELEMS cycles, incrementing k each cycle, then enter DONE.
REQ-024 In DONE the block SHALL assert Done=1 for one cycle with RD_s=WR_s=0, then return to IDLE.
REQ-025 RD_s and WR_s SHALL never be high in the same cycle.
REQ-026 Addr and Addr2 SHALL be stable for the whole of each READ and WRITE phase; outside those phases Addr and Addr2 SHALL hold their last value.
REQ-027 Latency SHALL be fixed: with Start sampled at edge E0, READ SHALL span E0..E15, DRAIN E16, WRITE E17..E32 and DONE E33, and Done SHALL be high in the cycle after E33.
REQ-028 Dst equal to SrcA or SrcB SHALL be legal and SHALL produce correct results, because all reads complete before the first write.
REQ-029 Back-to-back commands SHALL be legal: Start may be accepted in the cycle after DONE.

Reset
REQ-030 With Rst=1 at an edge, the FSM SHALL enter IDLE and k, RD_s, WR_s, Done, Busy, Ovf, Addr, Addr2 and DataIn_s SHALL all become 0; buffer contents are don't-care.
REQ-031 Rst SHALL take priority over Start.
REQ-032 Rst mid-operation SHALL abort the operation with no further WR_s pulses; a partially written Dst is permitted.
REQ-033 After Rst deasserts, the first accepted Start SHALL behave exactly per REQ-027.

Verification
REQ-034 ADD: A[j]=j, B[j]=0x0100+j, Dst=2 -> WR_s high E17..E32 with DataIn_s = 0x0100+2j; Done at E33; Ovf=0.
REQ-035 SADD: A[j]=0x7FF0, B[j]=0x0020 -> all 16 elements written as 0x7FFF; Ovf=1. Also A=0x8000, B=0xFFFF -> 0x8000; Ovf=1.
REQ-036 SUB in place, SrcA=Dst=1: A[j]=0, B[j]=1 -> vector 1 becomes all 0xFFFF; Ovf=1.
REQ-037 SMAX: A=0xFFFF (-1), B=0x0001 -> 0x0001; tie A=B=0x1234 -> 0x1234; Ovf=0.
REQ-038 Rst at E20 (during WRITE) -> RD_s=WR_s=0 from the next cycle; Busy=0; no Done; a fresh Start then completes in 34 cycles.
REQ-039 Start pulsed during READ and DONE -> ignored; checker confirms RD_s&WR_s is never 1 and a zero-enable gap precedes every READ and WRITE phase.

Source files
------------

// File: rtl/valu_serial.sv
`default_nettype none
// ============================================================================
//  Module   : valu_serial
//  Purpose  : Serial vector ALU. Streams ELEMS elements of two source vector
//             registers out of a register file, applies ADD / SUB / SADD /
//             SMAX element-wise into a local result buffer, then streams the
//             buffer back into the destination vector register. All reads
//             finish before the first write, so the destination may alias
//             either source.
//
//  Ports    : Clk1        in   single clock, rising edge
//             Rst         in   synchronous active-high reset
//             Start       in   command strobe, only looked at while idle
//             Op[1:0]     in   00 ADD, 01 SUB (A-B), 10 SADD, 11 SMAX
//             SrcA/SrcB/Dst[2:0] in  vector register numbers
//             DataOut_s   in   A element stream, one cycle behind RD_s
//             DataOut2_s  in   B element stream, one cycle behind RD_s
//             Addr/Addr2  out  register-file addresses
//             RD_s/WR_s   out  serial read / write enables
//             DataIn_s    out  serial write-back element
//             Busy        out  high whenever not idle
//             Done        out  one-cycle completion pulse
//             Ovf         out  carry/borrow/saturation seen in the last op
//
//  Revision : 1.0  initial release
// ============================================================================
module valu_serial #(
    parameter int ELEMS = 16
) (
    input  logic        Clk1,
    input  logic        Rst,
    input  logic        Start,
    input  logic [1:0]  Op,
    input  logic [2:0]  SrcA,
    input  logic [2:0]  SrcB,
    input  logic [2:0]  Dst,
    input  logic [15:0] DataOut_s,
    input  logic [15:0] DataOut2_s,
    output logic [2:0]  Addr,
    output logic [2:0]  Addr2,
    output logic        RD_s,
    output logic        WR_s,
    output logic [15:0] DataIn_s,
    output logic        Busy,
    output logic        Done,
    output logic        Ovf
);

    localparam int            c_KW     = (ELEMS > 1) ? $clog2(ELEMS) : 1;
    localparam logic [c_KW-1:0] c_K_LAST = c_KW'(ELEMS - 1);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_READ  = 3'd1;
    localparam logic [2:0] c_DRAIN = 3'd2;
    localparam logic [2:0] c_WRITE = 3'd3;
    localparam logic [2:0] c_DONE  = 3'd4;

    localparam logic [1:0] c_OP_ADD  = 2'b00;
    localparam logic [1:0] c_OP_SUB  = 2'b01;
    localparam logic [1:0] c_OP_SADD = 2'b10;

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic [c_KW-1:0]  r_k;
    logic [1:0]       r_op;
    logic [2:0]       r_dst;
    logic [2:0]       r_addr;
    logic [2:0]       r_addr2;
    logic             r_ovf;
    logic [15:0]      r_buf [ELEMS];

    logic             w_k_last;
    logic             w_capture;
    logic [c_KW-1:0]  w_cap_idx;
    logic [16:0]      w_sum;
    logic [16:0]      w_diff;
    logic             w_sadd_ovf;
    logic [15:0]      w_res;
    logic             w_res_ovf;

    assign w_k_last = (r_k == c_K_LAST);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge Clk1) begin
        if (Rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next state and control outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        RD_s        = 1'b0;
        WR_s        = 1'b0;
        Done        = 1'b0;
        Busy        = 1'b1;
        DataIn_s    = 16'h0000;
        case (r_state)
            c_IDLE: begin
                Busy = 1'b0;
                if (Start) begin
                    w_state_nxt = c_READ;
                end
            end
            c_READ: begin
                RD_s = 1'b1;
                if (w_k_last) begin
                    w_state_nxt = c_DRAIN;
                end
            end
            c_DRAIN: begin
                // Both enables low here: the final element is still in flight
                // and the register file gets an idle cycle between phases.
                w_state_nxt = c_WRITE;
            end
            c_WRITE: begin
                WR_s     = 1'b1;
                DataIn_s = r_buf[r_k];
                if (w_k_last) begin
                    w_state_nxt = c_DONE;
                end
            end
            c_DONE: begin
                Done        = 1'b1;
                w_state_nxt = c_IDLE;
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Element ALU. The read data trails RD_s by one cycle, so the element
    // arriving in READ cycle k (k>=1) belongs to index k-1, and the last one
    // arrives during DRAIN.
    // ------------------------------------------------------------------------
    assign w_capture = ((r_state == c_READ) && (r_k != '0)) || (r_state == c_DRAIN);
    assign w_cap_idx = (r_state == c_DRAIN) ? c_K_LAST : (r_k - c_KW'(1));

    assign w_sum      = {1'b0, DataOut_s} + {1'b0, DataOut2_s};
    assign w_diff     = {1'b0, DataOut_s} - {1'b0, DataOut2_s};
    assign w_sadd_ovf = (DataOut_s[15] == DataOut2_s[15]) && (w_sum[15] != DataOut_s[15]);

    always_comb begin
        w_res     = w_sum[15:0];
        w_res_ovf = 1'b0;
        case (r_op)
            c_OP_ADD: begin
                w_res     = w_sum[15:0];
                w_res_ovf = w_sum[16];
            end
            c_OP_SUB: begin
                // Bit 16 of the zero-extended difference is the borrow.
                w_res     = w_diff[15:0];
                w_res_ovf = w_diff[16];
            end
            c_OP_SADD: begin
                if (w_sadd_ovf) begin
                    w_res = DataOut_s[15] ? 16'h8000 : 16'h7FFF;
                end else begin
                    w_res = w_sum[15:0];
                end
                w_res_ovf = w_sadd_ovf;
            end
            default: begin
                // SMAX: ties resolve to A.
                w_res     = ($signed(DataOut_s) >= $signed(DataOut2_s)) ? DataOut_s : DataOut2_s;
                w_res_ovf = 1'b0;
            end
        endcase
    end

    // Result buffer carries no reset; its contents are rewritten before use.
    always_ff @(posedge Clk1) begin
        if (w_capture) begin
            r_buf[w_cap_idx] <= w_res;
        end
    end

    // ------------------------------------------------------------------------
    // Counter, command latches, addresses and overflow flag
    // ------------------------------------------------------------------------
    always_ff @(posedge Clk1) begin
        if (Rst) begin
            r_k     <= '0;
            r_op    <= 2'b00;
            r_dst   <= 3'd0;
            r_addr  <= 3'd0;
            r_addr2 <= 3'd0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (Start) begin
                        r_op    <= Op;
                        r_dst   <= Dst;
                        r_addr  <= SrcA;
                        r_addr2 <= SrcB;
                        r_ovf   <= 1'b0;
                        r_k     <= '0;
                    end
                end
                c_READ: begin
                    r_k <= w_k_last ? '0 : (r_k + c_KW'(1));
                end
                c_DRAIN: begin
                    // Switch the address during the gap so it is already
                    // stable on the first WRITE cycle.
                    r_k    <= '0;
                    r_addr <= r_dst;
                end
                c_WRITE: begin
                    r_k <= w_k_last ? '0 : (r_k + c_KW'(1));
                end
                default: begin
                end
            endcase
            if (w_capture && w_res_ovf) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign Addr  = r_addr;
    assign Addr2 = r_addr2;
    assign Ovf   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_valu_serial.sv
`default_nettype none
// ============================================================================
//  Module   : tb_valu_serial
//  Purpose  : Self-checking bench for valu_serial with a behavioural register
//             file and an arithmetic reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_valu_serial;

    localparam int N = 16;
    localparam int T = 2 * N + 3;   // samples taken after edges E0 .. E(2N+2)

    logic        Clk1 = 1'b0;
    logic        Rst = 1'b1;
    logic        Start = 1'b0;
    logic [1:0]  Op = 2'b00;
    logic [2:0]  SrcA = 3'd0;
    logic [2:0]  SrcB = 3'd0;
    logic [2:0]  Dst = 3'd0;
    logic [15:0] DataOut_s = 16'h0000;
    logic [15:0] DataOut2_s = 16'h0000;
    logic [2:0]  Addr;
    logic [2:0]  Addr2;
    logic        RD_s;
    logic        WR_s;
    logic [15:0] DataIn_s;
    logic        Busy;
    logic        Done;
    logic        Ovf;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem [8][N];
    int rd_cnt = 0;
    int wr_cnt = 0;

    logic [T-1:0] exp_rd, exp_wr, exp_dn, exp_bz;
    logic [T-1:0] obs_rd, obs_wr, obs_dn, obs_bz;
    logic [1:0]   obs_ovf;
    bit           obs_addr_bad, obs_mem_bad, exp_ovf;

    int  both_viol = 0;
    int  gap_viol = 0;
    logic prev_rd = 1'b0;
    logic prev_wr = 1'b0;

    always #5 Clk1 = ~Clk1;

    valu_serial #(.ELEMS(N)) dut (
        .Clk1(Clk1), .Rst(Rst), .Start(Start), .Op(Op),
        .SrcA(SrcA), .SrcB(SrcB), .Dst(Dst),
        .DataOut_s(DataOut_s), .DataOut2_s(DataOut2_s),
        .Addr(Addr), .Addr2(Addr2), .RD_s(RD_s), .WR_s(WR_s),
        .DataIn_s(DataIn_s), .Busy(Busy), .Done(Done), .Ovf(Ovf)
    );

    // Register file: burst counters restart whenever the enable is low.
    always @(posedge Clk1) begin
        if (RD_s === 1'b1) begin
            DataOut_s  <= mem[Addr][rd_cnt % N];
            DataOut2_s <= mem[Addr2][rd_cnt % N];
            rd_cnt     <= rd_cnt + 1;
        end else begin
            DataOut_s  <= 16'hDEAD;
            DataOut2_s <= 16'hBEEF;
            rd_cnt     <= 0;
        end
        if (WR_s === 1'b1) begin
            mem[Addr][wr_cnt % N] <= DataIn_s;
            wr_cnt <= wr_cnt + 1;
        end else begin
            wr_cnt <= 0;
        end
    end

    // Protocol monitor: no overlap, and an all-low cycle before each phase.
    always @(negedge Clk1) begin
        if (RD_s === 1'b1 && WR_s === 1'b1) both_viol++;
        if (RD_s === 1'b1 && prev_rd !== 1'b1 && prev_wr === 1'b1) gap_viol++;
        if (WR_s === 1'b1 && prev_wr !== 1'b1 && prev_rd === 1'b1) gap_viol++;
        prev_rd <= RD_s;
        prev_wr <= WR_s;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    // Reference: {overflow, result} from plain integer arithmetic.
    function automatic logic [16:0] ref_elem(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        int ia, ib, sa, sb, r;
        logic ov;
        ia = int'(a);
        ib = int'(b);
        sa = (ia >= 32768) ? ia - 65536 : ia;
        sb = (ib >= 32768) ? ib - 65536 : ib;
        ov = 1'b0;
        case (op)
            2'b00: begin r = ia + ib; ov = (r > 65535); r = r % 65536; end
            2'b01: begin r = ia - ib; ov = (r < 0); if (r < 0) r = r + 65536; end
            2'b10: begin
                r = sa + sb;
                if (r > 32767) begin r = 32767; ov = 1'b1; end
                else if (r < -32768) begin r = -32768; ov = 1'b1; end
                if (r < 0) r = r + 65536;
            end
            default: r = (sa >= sb) ? ia : ib;
        endcase
        return {ov, r[15:0]};
    endfunction

    function automatic logic [15:0] rnd_val();
        case ($urandom_range(0, 5))
            0: return 16'h7FFF;
            1: return 16'h8000;
            2: return 16'hFFFF;
            3: return 16'h0000;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic fill_random();
        for (int r = 0; r < 8; r++)
            for (int j = 0; j < N; j++) mem[r][j] = rnd_val();
    endtask

    // Run one command from Start and record what was observed.
    task automatic do_op(input logic [1:0] op, input logic [2:0] a, input logic [2:0] b,
                         input logic [2:0] d, input bit poke);
        logic [15:0] post [8][N];
        logic [16:0] r;
        post = mem;
        exp_ovf = 1'b0;
        for (int j = 0; j < N; j++) begin
            r = ref_elem(op, mem[a][j], mem[b][j]);
            post[d][j] = r[15:0];
            exp_ovf = exp_ovf | r[16];
        end
        obs_addr_bad = 1'b0;
        @(negedge Clk1);
        Op = op; SrcA = a; SrcB = b; Dst = d; Start = 1'b1;
        for (int n = 0; n < T; n++) begin
            @(posedge Clk1);
            #1;
            Start = 1'b0;
            if (poke && (n == 5 || n == 2 * N + 1)) begin
                Start = 1'b1; Op = ~op; SrcA = ~a; SrcB = ~b; Dst = ~d;
            end
            obs_rd[n] = RD_s;
            obs_wr[n] = WR_s;
            obs_dn[n] = Done;
            obs_bz[n] = Busy;
            if (n < N && (Addr !== a || Addr2 !== b)) obs_addr_bad = 1'b1;
            if (n == N && Addr !== a) obs_addr_bad = 1'b1;
            if (n > N && Addr !== d) obs_addr_bad = 1'b1;
            if (n == 2 * N + 1) obs_ovf[1] = Ovf;
            if (n == 2 * N + 2) obs_ovf[0] = Ovf;
        end
        obs_mem_bad = 1'b0;
        for (int rr = 0; rr < 8; rr++)
            for (int j = 0; j < N; j++)
                if (mem[rr][j] !== post[rr][j]) obs_mem_bad = 1'b1;
    endtask

    task automatic test_reset();
        Rst = 1'b1; Start = 1'b1; Op = 2'b01; SrcA = 3'd5; SrcB = 3'd6; Dst = 3'd7;
        repeat (3) @(posedge Clk1);
        #1;
        checks++;
        if ({RD_s, WR_s, Busy, Done, Ovf} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl got %b expected 00000", {RD_s, WR_s, Busy, Done, Ovf});
        end
        checks++;
        if ({Addr, Addr2, DataIn_s} !== 22'h0) begin
            errors++; $display("FAIL reset_data got Addr=%0d Addr2=%0d DataIn=%h expected 0 0 0000", Addr, Addr2, DataIn_s);
        end
        @(negedge Clk1);
        Rst = 1'b0; Start = 1'b0;
        @(posedge Clk1);
        #1;
        checks++;
        if (Busy !== 1'b0) begin
            errors++; $display("FAIL reset_idle got Busy=%b expected 0", Busy);
        end
    endtask

    task automatic test_add();
        for (int j = 0; j < N; j++) begin mem[0][j] = 16'(j); mem[1][j] = 16'(16'h0100 + j); end
        do_op(2'b00, 3'd0, 3'd1, 3'd2, 1'b0);
        checks++;
        if ({obs_rd, obs_wr, obs_dn, obs_bz} !== {exp_rd, exp_wr, exp_dn, exp_bz}) begin
            errors++; $display("FAIL add_timing got rd=%h wr=%h dn=%h bz=%h expected rd=%h wr=%h dn=%h bz=%h",
                               obs_rd, obs_wr, obs_dn, obs_bz, exp_rd, exp_wr, exp_dn, exp_bz);
        end
        checks++;
        if (obs_addr_bad) begin errors++; $display("FAIL add_addr got unstable/incorrect address expected stable"); end
        for (int j = 0; j < N; j++) begin
            checks++;
            if (mem[2][j] !== 16'(16'h0100 + 2 * j)) begin
                errors++; $display("FAIL add_elem%0d got %h expected %h", j, mem[2][j], 16'(16'h0100 + 2 * j));
            end
        end
        checks++;
        if (obs_ovf !== 2'b00) begin errors++; $display("FAIL add_ovf got %b expected 00", obs_ovf); end
    endtask

    task automatic test_sadd();
        for (int j = 0; j < N; j++) begin mem[3][j] = 16'h7FF0; mem[4][j] = 16'h0020; end
        do_op(2'b10, 3'd3, 3'd4, 3'd5, 1'b0);
        checks++;
        if (mem[5][0] !== 16'h7FFF || mem[5][N-1] !== 16'h7FFF || obs_mem_bad) begin
            errors++; $display("FAIL sadd_pos got e0=%h e15=%h expected 7fff", mem[5][0], mem[5][N-1]);
        end
        checks++;
        if (obs_ovf !== 2'b11) begin errors++; $display("FAIL sadd_pos_ovf got %b expected 11", obs_ovf); end
        for (int j = 0; j < N; j++) begin mem[3][j] = 16'h8000; mem[4][j] = 16'hFFFF; end
        do_op(2'b10, 3'd3, 3'd4, 3'd6, 1'b0);
        checks++;
        if (mem[6][0] !== 16'h8000 || mem[6][N-1] !== 16'h8000 || obs_mem_bad) begin
            errors++; $display("FAIL sadd_neg got e0=%h e15=%h expected 8000", mem[6][0], mem[6][N-1]);
        end
        checks++;
        if (obs_ovf !== 2'b11) begin errors++; $display("FAIL sadd_neg_ovf got %b expected 11", obs_ovf); end
    endtask

    task automatic test_sub_inplace();
        for (int j = 0; j < N; j++) begin mem[1][j] = 16'h0000; mem[2][j] = 16'h0001; end
        do_op(2'b01, 3'd1, 3'd2, 3'd1, 1'b0);
        checks++;
        if (mem[1][0] !== 16'hFFFF || mem[1][N-1] !== 16'hFFFF || obs_mem_bad) begin
            errors++; $display("FAIL sub_inplace got e0=%h e15=%h expected ffff", mem[1][0], mem[1][N-1]);
        end
        checks++;
        if (obs_ovf !== 2'b11) begin errors++; $display("FAIL sub_ovf got %b expected 11", obs_ovf); end
    endtask

    task automatic test_smax();
        for (int j = 0; j < N; j++) begin mem[0][j] = 16'hFFFF; mem[1][j] = 16'h0001; end
        do_op(2'b11, 3'd0, 3'd1, 3'd3, 1'b0);
        checks++;
        if (mem[3][0] !== 16'h0001 || mem[3][N-1] !== 16'h0001 || obs_ovf !== 2'b00) begin
            errors++; $display("FAIL smax_sign got e0=%h ovf=%b expected 0001 00", mem[3][0], obs_ovf);
        end
        for (int j = 0; j < N; j++) begin mem[0][j] = 16'h1234; mem[1][j] = 16'h1234; end
        do_op(2'b11, 3'd0, 3'd1, 3'd4, 1'b0);
        checks++;
        if (mem[4][7] !== 16'h1234 || obs_mem_bad || obs_ovf !== 2'b00) begin
            errors++; $display("FAIL smax_tie got e7=%h ovf=%b expected 1234 00", mem[4][7], obs_ovf);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 10; i++) begin
            fill_random();
            do_op(2'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 1'b0);
            checks++;
            if (obs_mem_bad || obs_addr_bad) begin
                errors++; $display("FAIL random%0d_data got mem_bad=%b addr_bad=%b expected 0 0", i, obs_mem_bad, obs_addr_bad);
            end
            checks++;
            if (obs_ovf !== {2{exp_ovf}}) begin
                errors++; $display("FAIL random%0d_ovf got %b expected %b", i, obs_ovf, {2{exp_ovf}});
            end
        end
    endtask

    task automatic test_start_ignored();
        fill_random();
        do_op(2'b10, 3'd2, 3'd5, 3'd2, 1'b1);
        checks++;
        if ({obs_rd, obs_wr, obs_dn, obs_bz} !== {exp_rd, exp_wr, exp_dn, exp_bz} || obs_addr_bad) begin
            errors++; $display("FAIL ignore_timing got rd=%h wr=%h dn=%h bz=%h addr_bad=%b expected rd=%h wr=%h dn=%h bz=%h 0",
                               obs_rd, obs_wr, obs_dn, obs_bz, obs_addr_bad, exp_rd, exp_wr, exp_dn, exp_bz);
        end
        checks++;
        if (obs_mem_bad || obs_ovf !== {2{exp_ovf}}) begin
            errors++; $display("FAIL ignore_data got mem_bad=%b ovf=%b expected 0 %b", obs_mem_bad, obs_ovf, {2{exp_ovf}});
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            fill_random();
            do_op(2'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 1'b0);
            checks++;
            if ({obs_rd, obs_wr, obs_dn, obs_bz} !== {exp_rd, exp_wr, exp_dn, exp_bz} || obs_mem_bad) begin
                errors++; $display("FAIL b2b%0d got rd=%h wr=%h dn=%h mem_bad=%b expected rd=%h wr=%h dn=%h 0",
                                   i, obs_rd, obs_wr, obs_dn, obs_mem_bad, exp_rd, exp_wr, exp_dn);
            end
        end
    endtask

    task automatic test_reset_mid();
        int wr_seen;
        int done_seen;
        for (int j = 0; j < N; j++) begin mem[3][j] = 16'h7FF0; mem[4][j] = 16'h0020; end
        @(negedge Clk1);
        Op = 2'b10; SrcA = 3'd3; SrcB = 3'd4; Dst = 3'd6; Start = 1'b1;
        @(posedge Clk1);
        #1;
        Start = 1'b0;
        repeat (19) @(posedge Clk1);
        #1;
        checks++;
        if ({WR_s, Ovf} !== 2'b11) begin
            errors++; $display("FAIL midrst_pre got WR_s,Ovf=%b expected 11", {WR_s, Ovf});
        end
        Rst = 1'b1;
        @(posedge Clk1);
        #1;
        checks++;
        if ({RD_s, WR_s, Busy, Done, Ovf, Addr, Addr2, DataIn_s} !== 27'h0) begin
            errors++; $display("FAIL midrst_clear got rd=%b wr=%b busy=%b done=%b ovf=%b addr=%0d expected all 0",
                               RD_s, WR_s, Busy, Done, Ovf, Addr);
        end
        Rst = 1'b0;
        wr_seen = 0;
        done_seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge Clk1);
            #1;
            if (WR_s !== 1'b0) wr_seen++;
            if (Done !== 1'b0) done_seen++;
        end
        checks++;
        if (wr_seen != 0 || done_seen != 0) begin
            errors++; $display("FAIL midrst_quiet got wr=%0d done=%0d expected 0 0", wr_seen, done_seen);
        end
        fill_random();
        do_op(2'b00, 3'd1, 3'd6, 3'd6, 1'b0);
        checks++;
        if ({obs_rd, obs_wr, obs_dn, obs_bz} !== {exp_rd, exp_wr, exp_dn, exp_bz} || obs_mem_bad) begin
            errors++; $display("FAIL midrst_fresh got rd=%h wr=%h dn=%h mem_bad=%b expected rd=%h wr=%h dn=%h 0",
                               obs_rd, obs_wr, obs_dn, obs_mem_bad, exp_rd, exp_wr, exp_dn);
        end
    endtask

    task automatic test_protocol();
        checks++;
        if (both_viol != 0) begin errors++; $display("FAIL proto_overlap got %0d expected 0", both_viol); end
        checks++;
        if (gap_viol != 0) begin errors++; $display("FAIL proto_gap got %0d expected 0", gap_viol); end
    endtask

    initial begin
        exp_rd = '0; exp_wr = '0; exp_dn = '0; exp_bz = '0;
        for (int n = 0; n < N; n++) exp_rd[n] = 1'b1;
        for (int n = N + 1; n <= 2 * N; n++) exp_wr[n] = 1'b1;
        exp_dn[2 * N + 1] = 1'b1;
        for (int n = 0; n <= 2 * N + 1; n++) exp_bz[n] = 1'b1;

        test_reset();
        test_add();
        test_sadd();
        test_sub_inplace();
        test_smax();
        test_random();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        test_protocol();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
